// File: rtl/fb_pkg.sv
// fb_pkg: constants and state encoding shared by the frame-buffer reader and
// writer blocks.
//   FB_WIDTH/FB_HEIGHT : frame geometry in pixels
//   FB_PIXELS          : pixels per frame
//   FB_ADDR_W          : buffer address width (2**FB_ADDR_W >= FB_PIXELS)
//   FB_DATA_W          : pixel width
//   fb_state_e         : IDLE / RUN / DRAIN sweep state
package fb_pkg;

  localparam int unsigned FB_WIDTH  = 320;
  localparam int unsigned FB_HEIGHT = 240;
  localparam int unsigned FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned FB_ADDR_W = 17;
  localparam int unsigned FB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fb_state_e;

endpackage

// File: rtl/fb_skid_fifo.sv
// fb_skid_fifo: 2-entry first-word-fall-through FIFO. slot0 is always the
// head, so dout_o needs no read mux. Push and pop may happen in the same
// cycle at any occupancy; a pop on empty or a push on full without a pop is
// ignored.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset (flushes contents)
//   push_i/din_i : write request and entry
//   pop_i        : consume the head entry
//   dout_o       : head entry (valid when valid_o)
//   valid_o      : FIFO not empty
//   count_o      : occupancy 0..2
module fb_skid_fifo #(
  parameter int unsigned ENTRY_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] din_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] dout_o,
  output logic               valid_o,
  output logic [1:0]         count_o
);

  logic [ENTRY_W-1:0] slot0_q, slot0_d;
  logic [ENTRY_W-1:0] slot1_q, slot1_d;
  logic [1:0]         count_q, count_d;
  logic               do_pop, do_push;
  logic [1:0]         occ_after_pop;

  always_comb begin
    do_pop        = pop_i && (count_q != 2'd0);
    do_push       = push_i && ((count_q != 2'd2) || do_pop);
    occ_after_pop = count_q - {1'b0, do_pop};
    slot0_d       = slot0_q;
    slot1_d       = slot1_q;
    count_d       = occ_after_pop + {1'b0, do_push};
    if (do_pop) begin
      slot0_d = slot1_q;
    end
    // The write slot is chosen from the occupancy left after this cycle's pop.
    if (do_push) begin
      if (occ_after_pop == 2'd0) begin
        slot0_d = din_i;
      end else begin
        slot1_d = din_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign dout_o  = slot0_q;
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/fb_stream_reader.sv
// fb_stream_reader: sweeps the frame buffer read port in raster order after a
// start pulse and presents the pixels as a valid/ready stream. Reads are only
// issued while FIFO occupancy plus the in-flight read (net of a same-cycle
// pop) is below 2, so the 2-entry FIFO absorbs the 1-cycle BRAM latency and
// back-pressure never drops or repeats a pixel, while still sustaining one
// pixel per clock.
// Optional build macro: FB_RD_MARKERS_EN adds out_sof/out_eol frame markers.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   start                : one-cycle frame request, honoured only in IDLE
//   busy                 : frame in progress (low again in the frame_done cycle)
//   frame_done           : one-cycle pulse after the last pixel is accepted
//   rd_addr / rd_data    : buffer read port, data valid one cycle after addr
//   out_data/out_valid/out_ready : pixel stream
//   out_sof/out_eol      : first pixel of frame / last pixel of line (macro only)
module fb_stream_reader
  import fb_pkg::*;
#(
  parameter int unsigned WIDTH  = FB_WIDTH,
  parameter int unsigned HEIGHT = FB_HEIGHT,
  parameter int unsigned DATA_W = FB_DATA_W,
  parameter int unsigned ADDR_W = FB_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef FB_RD_MARKERS_EN
  ,
  output logic              out_sof,
  output logic              out_eol
`endif
);

  localparam int unsigned PIXELS = WIDTH * HEIGHT;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
`ifdef FB_RD_MARKERS_EN
  localparam int unsigned TAG_W = 2;
  localparam int unsigned XW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`else
  localparam int unsigned TAG_W = 0;
`endif
  localparam int unsigned ENTRY_W = DATA_W + TAG_W;

  fb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              inflight_q, inflight_d;

  logic [ENTRY_W-1:0] fifo_din, fifo_head;
  logic               fifo_valid;
  logic [1:0]         fifo_count;
  logic               pop, issue, credit_ok;
  logic [2:0]         occupancy;

`ifdef FB_RD_MARKERS_EN
  // Only the x position matters for the markers: sof is simply address 0.
  logic [XW-1:0]    x_q, x_d;
  logic [TAG_W-1:0] tag_q, tag_d;
`endif

  always_comb begin
    pop        = fifo_valid && out_ready;
    occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q};
    // A pop in the same cycle frees a slot immediately.
    credit_ok  = occupancy < (3'd2 + {2'b00, pop});
    issue      = (state_q == RUN) && credit_ok;

    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    inflight_d = issue;
    busy       = 1'b0;
    frame_done = 1'b0;
`ifdef FB_RD_MARKERS_EN
    x_d        = x_q;
    tag_d      = tag_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          rd_addr_d = '0;
`ifdef FB_RD_MARKERS_EN
          x_d       = '0;
`endif
        end
      end
      RUN: begin
        busy = 1'b1;
        if (issue) begin
          rd_addr_d = rd_addr_q + 1'b1;
          if (rd_addr_q == LAST_ADDR) begin
            state_d = DRAIN;
          end
`ifdef FB_RD_MARKERS_EN
          tag_d = {rd_addr_q == '0, x_q == XW'(WIDTH - 1)};
          x_d   = (x_q == XW'(WIDTH - 1)) ? '0 : x_q + 1'b1;
`endif
        end
      end
      DRAIN: begin
        if ((fifo_count == 2'd0) && !inflight_q) begin
          state_d    = IDLE;
          frame_done = 1'b1;
        end else begin
          busy = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_addr_q  <= '0;
      inflight_q <= 1'b0;
`ifdef FB_RD_MARKERS_EN
      x_q        <= '0;
      tag_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      inflight_q <= inflight_d;
`ifdef FB_RD_MARKERS_EN
      x_q        <= x_d;
      tag_q      <= tag_d;
`endif
    end
  end

`ifdef FB_RD_MARKERS_EN
  assign fifo_din = {tag_q, rd_data};
`else
  assign fifo_din = rd_data;
`endif

  fb_skid_fifo #(
    .ENTRY_W (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (inflight_q),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (fifo_head),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  assign rd_addr   = rd_addr_q;
  assign out_valid = fifo_valid;
  assign out_data  = fifo_head[DATA_W-1:0];
`ifdef FB_RD_MARKERS_EN
  assign out_sof   = fifo_valid && fifo_head[DATA_W+1];
  assign out_eol   = fifo_valid && fifo_head[DATA_W];
`endif

endmodule

// File: tb/tb_fb_stream_reader.sv
// Directed bench for fb_stream_reader on a reduced 24x12 frame. A behavioural
// 1-cycle-latency buffer model supplies pixel patterns; expected pixels are
// queued at start and popped on each accepted transfer.
module tb_fb_stream_reader;

  localparam int unsigned W  = 24;
  localparam int unsigned H  = 12;
  localparam int unsigned P  = W * H;
  localparam int unsigned AW = 17;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, frame_done, out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] out_data;
`ifdef FB_RD_MARKERS_EN
  logic          out_sof, out_eol;
`endif

  always #5 clk = ~clk;

  fb_stream_reader #(
    .WIDTH  (W),
    .HEIGHT (H),
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
`ifdef FB_RD_MARKERS_EN
    ,
    .out_sof    (out_sof),
    .out_eol    (out_eol)
`endif
  );

  int unsigned pat = 0;

  function automatic logic [DW-1:0] pix(input int unsigned a, input int unsigned p);
    int unsigned v;
    case (p)
      0:       v = a;
      1:       v = a * 5 + 3;
      2:       v = a ^ (a >> 3) ^ 8'h5a;
      default: v = a * 13 + 7;
    endcase
    return v[DW-1:0];
  endfunction

  // Frame buffer read port: registered read, 1-cycle latency.
  always @(posedge clk) rd_data <= pix(int'(rd_addr), pat);

  int unsigned n_vec = 0, n_bad = 0;
  int unsigned cyc = 0, accepted = 0, done_cnt = 0, done_cyc = 0;
  int unsigned first_valid_cyc = 0, gaps = 0, eol_cnt = 0;
  bit          seen_valid = 0, prev_stall = 0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_frame(input int unsigned p);
    pat = p;
    exp_q.delete();
    for (int unsigned k = 0; k < P; k++) exp_q.push_back(pix(k, p));
    accepted = 0; done_cnt = 0; seen_valid = 0; gaps = 0; eol_cnt = 0;
  endtask

  // Called just after a falling edge with inputs already driven: observes the
  // current cycle, then advances to the next falling edge.
  task automatic tick();
    logic [DW-1:0] e;
    #1;
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, prev_data);
    end
    if (out_valid && !seen_valid) begin
      seen_valid = 1;
      first_valid_cyc = cyc;
    end
    if (seen_valid && !out_valid && accepted < P) gaps++;
    if (busy) chk("credit_bound", (int'(rd_addr) <= accepted + 2), 1);
    if (out_valid && out_ready && !rst) begin
      if (exp_q.size() == 0) begin
        chk("extra_pixel", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("pixel", out_data, e);
      end
`ifdef FB_RD_MARKERS_EN
      chk("sof", out_sof, accepted == 0);
      chk("eol", out_eol, (accepted % W) == W - 1);
      if (out_eol) eol_cnt++;
`endif
      accepted++;
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_low_at_done", busy, 0);
    end
    prev_stall = out_valid && !out_ready && !rst;
    prev_data  = out_data;
    @(negedge clk);
    cyc++;
  endtask

  int unsigned t0, guard, stall_acc;
  bit          pulsed;
  logic [DW-1:0] frozen;

  initial begin
    @(negedge clk);
    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_data", out_data, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Full frame, out_ready held high; second start in the frame_done cycle
    load_frame(0);
    out_ready = 1'b1;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    chk("c1_busy", busy, 1);
    chk("c1_addr", rd_addr, 0);
    for (int unsigned i = 0; i < P + 12; i++) begin
      start = (cyc == t0 + P + 3);
      tick();
    end
    start = 1'b0;
    chk("first_valid_latency", first_valid_cyc - t0, 3);
    chk("no_gaps", gaps, 0);
    chk("accepted", accepted, P);
    chk("done_count", done_cnt, 1);
    chk("done_latency", done_cyc - t0, P + 3);
    chk("idle_busy", busy, 0);
    chk("idle_valid", out_valid, 0);
    chk("queue_empty", exp_q.size(), 0);
`ifdef FB_RD_MARKERS_EN
    chk("eol_total", eol_cnt, H);
`endif

    // Random 30% ready, extra start while busy
    load_frame(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    pulsed = 0;
    guard = 0;
    while (done_cnt == 0 && guard < 20 * P) begin
      out_ready = ($urandom_range(0, 99) < 30);
      start = (!pulsed && accepted == 10);
      if (start) pulsed = 1;
      tick();
      guard++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    repeat (10) tick();
    chk("rand_done_count", done_cnt, 1);
    chk("rand_accepted", accepted, P);
    chk("rand_queue_empty", exp_q.size(), 0);
    chk("rand_idle_busy", busy, 0);

    // 50-cycle stall mid-line
    load_frame(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (accepted < 3 * W + 5 && guard < 4 * P) begin
      tick();
      guard++;
    end
    out_ready = 1'b0;
    tick();
    frozen = out_data;
    stall_acc = accepted;
    repeat (50) tick();
    chk("stall_data", out_data, frozen);
    chk("stall_valid", out_valid, 1);
    chk("stall_addr", rd_addr, stall_acc + 2);
    out_ready = 1'b1;
    guard = 0;
    while (done_cnt == 0 && guard < 4 * P) begin
      tick();
      guard++;
    end
    chk("stall_done_count", done_cnt, 1);
    chk("stall_accepted", accepted, P);

    // Reset mid-frame, then replay from address 0
    load_frame(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (accepted < P / 2 && guard < 4 * P) begin
      tick();
      guard++;
    end
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_addr", rd_addr, 0);
    chk("mrst_data", out_data, 0);
    repeat (5) tick();
    chk("mrst_no_done", done_cnt, 0);
    load_frame(3);
    out_ready = 1'b1;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    guard = 0;
    while (done_cnt == 0 && guard < 4 * P) begin
      tick();
      guard++;
    end
    chk("replay_done_count", done_cnt, 1);
    chk("replay_done_latency", done_cyc - t0, P + 3);
    chk("replay_accepted", accepted, P);
    chk("replay_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
